// File: rtl/data_mem_rmw.sv
// rtl/data_mem_rmw.sv - byte-addressed single-port data memory with read-modify-write store FSM
module data_mem_rmw #(
  parameter int N         = 32,
  parameter int ADDR_W    = 12,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [1:0]   req_size,
  input  logic         req_signed,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         rsp_valid,
  output logic [N-1:0] rsp_rdata,
  output logic         rsp_err
);
  localparam int NB    = N / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int ROW_W = ADDR_W - OFF_W;
  localparam int ROWS  = 1 << ROW_W;
  localparam int CNT_W = OFF_W + 2;
  localparam int WIN_B = 2 * NB;
  localparam logic [N-1:0] INIT_ROW = INIT_ZERO ? '0 : 'x;

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1, RESP} state_t;

  logic [N-1:0] mem [ROWS] = '{default: INIT_ROW};

  state_t           state;
  logic             wr_q, signed_q, cross_q, err_q;
  logic [1:0]       size_q;
  logic [OFF_W-1:0] off_q;
  logic [ROW_W-1:0] r0_q, r1;
  logic [N-1:0]     wdata_q, rd0_q, rd1_q;

  logic [OFF_W-1:0] req_off;
  logic [ROW_W-1:0] req_row;
  logic [CNT_W-1:0] req_bytes;
  logic             req_cross, req_bad;

  assign req_off   = req_addr[OFF_W-1:0];
  assign req_row   = req_addr[ADDR_W-1:OFF_W];
  assign req_cross = (CNT_W'(req_off) + req_bytes) > CNT_W'(NB);
  assign req_bad   = (req_addr[N-1:ADDR_W] != '0) || (req_cross && (&req_row)) || (req_size == 2'd3);
  assign r1        = r0_q + ROW_W'(1);

  always_comb begin
    req_bytes = CNT_W'(NB);
    case (req_size)
      2'd0:    req_bytes = CNT_W'(1);
      2'd1:    req_bytes = CNT_W'(2);
      default: req_bytes = CNT_W'(NB);
    endcase
  end

  // Two-row window {rd1, rd0}: stores shift data/lane mask into it, loads shift it down.
  logic [WIN_B-1:0] lane_mask;
  logic [2*N-1:0]   bit_mask, new_win, merged;
  logic [N-1:0]     load_raw, load_val;

  always_comb begin
    lane_mask = '0;
    bit_mask  = '0;
    case (size_q)
      2'd0:    lane_mask = WIN_B'(1) << off_q;
      2'd1:    lane_mask = WIN_B'(3) << off_q;
      default: lane_mask = WIN_B'({NB{1'b1}}) << off_q;
    endcase
    for (int i = 0; i < WIN_B; i++) bit_mask[i*8 +: 8] = {8{lane_mask[i]}};
    new_win  = {{N{1'b0}}, wdata_q} << {off_q, 3'b000};
    merged   = ({rd1_q, rd0_q} & ~bit_mask) | (new_win & bit_mask);
    load_raw = N'({rd1_q, rd0_q} >> {off_q, 3'b000});
    case (size_q)
      2'd0:    load_val = {{(N-8){signed_q & load_raw[7]}}, load_raw[7:0]};
      2'd1:    load_val = {{(N-16){signed_q & load_raw[15]}}, load_raw[15:0]};
      default: load_val = load_raw;
    endcase
  end

  // Writes live outside the reset block so an asynchronous reset during WRx suppresses the write.
  always_ff @(posedge clk) begin
    if (state == WR0)      mem[r0_q] <= merged[N-1:0];
    else if (state == WR1) mem[r1]   <= merged[2*N-1:N];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      wr_q      <= 1'b0;
      signed_q  <= 1'b0;
      cross_q   <= 1'b0;
      err_q     <= 1'b0;
      size_q    <= '0;
      off_q     <= '0;
      r0_q      <= '0;
      wdata_q   <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          req_ready <= 1'b0;
          wr_q      <= req_write;
          size_q    <= req_size;
          signed_q  <= req_signed;
          off_q     <= req_off;
          r0_q      <= req_row;
          cross_q   <= req_cross;
          wdata_q   <= req_wdata;
          err_q     <= req_bad;
          if (req_bad)                                                  state <= RESP;
          else if (req_write && req_size == 2'd2 && req_off == '0)      state <= WR0;
          else                                                          state <= RD0;
        end
        RD0: begin
          rd0_q <= mem[r0_q];
          state <= cross_q ? RD1 : (wr_q ? WR0 : RESP);
        end
        RD1: begin
          rd1_q <= mem[r1];
          state <= wr_q ? WR0 : RESP;
        end
        WR0:     state <= cross_q ? WR1 : RESP;
        WR1:     state <= RESP;
        RESP: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_rdata <= (err_q || wr_q) ? '0 : load_val;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_rmw.sv
// tb/tb_data_mem_rmw.sv - directed checks of data_mem_rmw loads, RMW stores, errors, reset and back-to-back
module tb_data_mem_rmw;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  data_mem_rmw #(.N(32), .ADDR_W(12), .INIT_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One request; cyc counts edges from the accept edge until rsp_valid is seen.
  task automatic xfer(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd, output logic er, output int cyc);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!rsp_valid && cyc < 20);
    if (!rsp_valid) check({tag, "_timeout"}, {31'b0, rsp_valid}, 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic do_load(input string tag, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] exp, input int exp_cyc);
    logic [31:0] rd; logic er; int cyc;
    xfer(tag, 1'b0, sz, sg, a, 32'h0, rd, er, cyc);
    check({tag, "_data"}, rd, exp);
    check({tag, "_err"}, {31'b0, er}, 32'd0);
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic do_store(input string tag, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int exp_cyc);
    logic [31:0] rd; logic er; int cyc;
    xfer(tag, 1'b1, sz, 1'b0, a, d, rd, er, cyc);
    check({tag, "_data"}, rd, 32'h0);
    check({tag, "_err"}, {31'b0, er}, 32'd0);
    check({tag, "_cyc"}, 32'(cyc), 32'(exp_cyc));
  endtask

  task automatic do_bad(input string tag, input logic w, input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] rd; logic er; int cyc;
    xfer(tag, w, sz, 1'b1, a, 32'h12345678, rd, er, cyc);
    check({tag, "_data"}, rd, 32'h0);
    check({tag, "_err"}, {31'b0, er}, 32'd1);
    check({tag, "_cyc"}, 32'(cyc), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err",   {31'b0, rsp_err}, 32'd0);

    do_store("t1_st",  2'd2, 32'h010, 32'hDEADBEEF, 2);
    do_load ("t1_ld",  2'd2, 1'b1, 32'h010, 32'hDEADBEEF, 2);

    do_store("t2_stb", 2'd0, 32'h011, 32'h00000080, 3);
    do_load ("t2_ldw", 2'd2, 1'b0, 32'h010, 32'hDEAD80EF, 2);
    do_load ("t2_lbs", 2'd0, 1'b1, 32'h011, 32'hFFFFFF80, 2);
    do_load ("t2_lbu", 2'd0, 1'b0, 32'h011, 32'h00000080, 2);
    do_load ("t2_lhs", 2'd1, 1'b1, 32'h012, 32'hFFFFDEAD, 2);
    do_load ("t2_lhu", 2'd1, 1'b0, 32'h012, 32'h0000DEAD, 2);

    do_store("t3_z0",  2'd2, 32'h010, 32'h0, 2);
    do_store("t3_z1",  2'd2, 32'h014, 32'h0, 2);
    do_store("t3_stx", 2'd2, 32'h013, 32'h11223344, 5);
    do_load ("t3_ld0", 2'd2, 1'b0, 32'h010, 32'h44000000, 2);
    do_load ("t3_ld1", 2'd2, 1'b0, 32'h014, 32'h00112233, 2);
    do_load ("t3_ldx", 2'd2, 1'b0, 32'h013, 32'h11223344, 3);

    do_store("t4_st",   2'd2, 32'hFFC, 32'hCAFEF00D, 2);
    do_bad  ("t4_oor",  1'b0, 2'd2, 32'h1000);
    do_bad  ("t4_sz3",  1'b0, 2'd3, 32'h020);
    do_bad  ("t4_top",  1'b0, 2'd2, 32'hFFE);
    do_bad  ("t4_stop", 1'b1, 2'd2, 32'hFFE);
    do_bad  ("t4_soor", 1'b1, 2'd0, 32'h1000);
    do_load ("t4_half", 2'd1, 1'b0, 32'hFFE, 32'h0000CAFE, 2);
    do_load ("t4_rel",  2'd2, 1'b0, 32'hFFC, 32'hCAFEF00D, 2);

    do_store("t5_p0",  2'd2, 32'h020, 32'hAAAAAAAA, 2);
    do_store("t5_p1",  2'd2, 32'h024, 32'hBBBBBBBB, 2);
    do_load ("t5_pre", 2'd2, 1'b0, 32'h020, 32'hAAAAAAAA, 2);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = 32'h023; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_ready", {31'b0, req_ready}, 32'd1);
    check("t5_valid", {31'b0, rsp_valid}, 32'd0);
    check("t5_rdata", rsp_rdata, 32'h0);
    check("t5_err",   {31'b0, rsp_err}, 32'd0);
    do_load ("t5_r0", 2'd2, 1'b0, 32'h020, 32'hAAAAAAAA, 2);
    do_load ("t5_r1", 2'd2, 1'b0, 32'h024, 32'hBBBBBBBB, 2);

    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0; req_addr = 32'h010;
    @(posedge clk); #1;
    check("t6_rdy_acc", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("t6_rdy_resp", {31'b0, req_ready}, 32'd0);
    @(posedge clk); #1;
    check("t6_rdy_idle", {31'b0, req_ready}, 32'd1);
    check("t6_v1",       {31'b0, rsp_valid}, 32'd1);
    check("t6_d1",       rsp_rdata, 32'h44000000);
    req_addr = 32'h014;
    @(posedge clk); #1;
    check("t6_rdy_acc2", {31'b0, req_ready}, 32'd0);
    check("t6_pulse",    {31'b0, rsp_valid}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("t6_v_mid",    {31'b0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    check("t6_v2",       {31'b0, rsp_valid}, 32'd1);
    check("t6_d2",       rsp_rdata, 32'h00112233);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
